uart_rx_fifo: RTL and testbench

- Receive front end of the RSA RFID datapath. It deserialises 8N1 UART frames from the host line and buffers the received bytes in a show-ahead FIFO.
- It supplies the byte/empty/read-request interface that the word-assembly stage consumes: key bytes, then modulus bytes, then plaintext bytes.
- It replaces the vendor FIFO plus ad-hoc receiver with one verifiable block.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/byte_fifo.sv | 71 +++++++
 rtl/uart_rx_fifo.sv | 161 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and baud-divider helper for the UART receive path.
package uart_pkg;

    localparam int BITS_PER_FRAME = 10;  // start + 8 data + stop
    localparam int OVERSAMPLE     = 16;
    localparam int MID_SAMPLE     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    // Clocks per oversample tick; integer division, remainder is dropped.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO with registered head, extended-pointer full/empty and sticky overflow.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  rd_en,
    output logic [7:0]            q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr_n;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx_n;
    logic                  do_push;
    logic                  do_pop;
    logic [7:0]            q_n;

    assign wr_idx = wr_ptr[DEPTH_LOG2-1:0];
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                    (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign usedw  = wr_ptr - rd_ptr;

    // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if the head leaves in the same cycle.
    assign do_pop   = rd_en && !empty;
    assign do_push  = wr_en && (!full || do_pop);
    assign rd_ptr_n = rd_ptr + (DEPTH_LOG2+1)'(do_pop);
    assign rd_idx_n = rd_ptr_n[DEPTH_LOG2-1:0];

    // Next head: bypass the incoming byte when it lands exactly where the head will point.
    always_comb begin
        q_n = mem[rd_idx_n];
        if (do_push && (wr_idx == rd_idx_n))
            q_n = wr_data;
    end

    // Storage array; no reset needed since q masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_idx] <= wr_data;
    end

    // Pointers, registered head mirror and sticky overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q        <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            rd_ptr <= rd_ptr_n;
            q      <= q_n;
            if (wr_en && full && !do_pop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampled) feeding a show-ahead byte FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  rdreq,
    output logic [7:0]            q,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   usedw,
    output logic                  frame_err,
    output logic                  overflow
);

    import uart_pkg::*;

    localparam int DIV      = calc_div(CLK_FREQ, BAUD);
    localparam int CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LAST_BIT = BITS_PER_FRAME - 3;

    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;

    rx_state_e        state,   state_n;
    logic [3:0]       s_cnt,   s_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg,   shreg_n;
    logic             armed,   armed_n;
    logic             push;
    logic             fe_set;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = (tick_cnt == CNT_W'(DIV - 1));

    // Receiver state register plus registered framing-error pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            armed     <= 1'b1;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            s_cnt     <= s_cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            armed     <= armed_n;
            frame_err <= fe_set;
        end
    end

    // Next-state logic; everything advances only on tick cycles.
    // After a bad stop bit the receiver stays disarmed until the line returns high,
    // so a held break is not mistaken for a stream of start bits.
    always_comb begin
        state_n   = state;
        s_cnt_n   = s_cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        armed_n   = armed;
        push      = 1'b0;
        fe_set    = 1'b0;
        if (tick) begin
            case (state)
                IDLE: begin
                    if (rx_s) begin
                        armed_n = 1'b1;
                    end else if (armed) begin
                        state_n = START;
                        s_cnt_n = '0;
                    end
                end
                START: begin
                    if (s_cnt == 4'(MID_SAMPLE - 1)) begin
                        s_cnt_n = '0;
                        if (!rx_s) begin
                            state_n   = DATA;
                            bit_idx_n = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                DATA: begin
                    if (s_cnt == 4'(OVERSAMPLE - 1)) begin
                        s_cnt_n = '0;
                        shreg_n = {rx_s, shreg[7:1]};
                        if (bit_idx == 3'(LAST_BIT))
                            state_n = STOP;
                        else
                            bit_idx_n = bit_idx + 3'd1;
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                STOP: begin
                    if (s_cnt == 4'(OVERSAMPLE - 1)) begin
                        s_cnt_n = '0;
                        state_n = IDLE;
                        if (rx_s) begin
                            push = 1'b1;
                        end else begin
                            fe_set  = 1'b1;
                            armed_n = 1'b0;
                        end
                    end else begin
                        s_cnt_n = s_cnt + 4'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    byte_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push),
        .wr_data  (shreg),
        .rd_en    (rdreq),
        .q        (q),
        .empty    (empty),
        .full     (full),
        .usedw    (usedw),
        .overflow (overflow)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table of single frames plus hand sequences for burst,
// overflow, glitch, push/pop at full and asynchronous reset mid-frame.
module tb_uart_rx_fifo;

    // Reduced line rate keeps the run short: DIV = 640000/(10000*16) = 4, 64 clk per bit.
    localparam int CLK_FREQ = 640000;
    localparam int BAUD     = 10000;
    localparam int DIV      = 4;
    localparam int BIT      = DIV * 16;
    localparam int FRAME    = BIT * 10;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rdreq = 1'b0;
    logic [7:0] q;
    logic       empty, full, frame_err, overflow;
    logic [4:0] usedw;

    int n_checks = 0;
    int n_fail   = 0;
    int fe_cnt   = 0;

    uart_rx_fifo #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(16), .DEPTH_LOG2(4)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .rdreq(rdreq), .q(q), .empty(empty),
        .full(full), .usedw(usedw), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err) fe_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " q"},         32'(q),         32'h0);
        check({tag, " empty"},     32'(empty),     32'h1);
        check({tag, " full"},      32'(full),      32'h0);
        check({tag, " usedw"},     32'(usedw),     32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check({tag, " overflow"},  32'(overflow),  32'h0);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = stop;
        wait_clk(BIT);
        rx = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        @(negedge clk);
        check({name, " empty"}, 32'(empty), 32'h0);
        check({name, " q"},     32'(q),     32'(exp));
        rdreq = 1'b1;
        @(negedge clk);
        rdreq = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        wait_clk(3);
        reset = 1'b0;
        wait_clk(BIT);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_used;
        int         exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int fe0;
        bit found;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_used: 1, exp_fe: 0};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_used: 1, exp_fe: 0};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_used: 1, exp_fe: 0};
        vecs[3] = '{data: 8'h3C, stop: 1'b0, exp_used: 0, exp_fe: 1};
        vecs[4] = '{data: 8'h80, stop: 1'b1, exp_used: 1, exp_fe: 0};
        vecs[5] = '{data: 8'h01, stop: 1'b1, exp_used: 1, exp_fe: 0};

        #1;
        check_reset_state("reset");
        check("calc_div default", 32'(uart_pkg::calc_div(50000000, 115200)), 32'd27);
        wait_clk(4);
        reset = 1'b0;
        wait_clk(BIT);

        // Single frames, one at a time, popped after each.
        foreach (vecs[i]) begin
            fe0 = fe_cnt;
            send_byte(vecs[i].data, vecs[i].stop);
            wait_clk(4);
            check($sformatf("vec%0d usedw", i), 32'(usedw), 32'(vecs[i].exp_used));
            check($sformatf("vec%0d frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            if (vecs[i].exp_used == 1) begin
                pop_check($sformatf("vec%0d pop", i), vecs[i].data);
                @(negedge clk);
                check($sformatf("vec%0d empty after pop", i), 32'(empty), 32'h1);
                check($sformatf("vec%0d usedw after pop", i), 32'(usedw), 32'h0);
            end else begin
                check($sformatf("vec%0d empty", i), 32'(empty), 32'h1);
            end
            wait_clk(BIT);
        end

        // Short low glitch on an idle line pushes nothing.
        fe0 = fe_cnt;
        rx = 1'b0;
        wait_clk(3);
        rx = 1'b1;
        wait_clk(2 * BIT);
        check("glitch usedw", 32'(usedw), 32'h0);
        check("glitch frame_err", 32'(fe_cnt - fe0), 32'h0);

        // rdreq on empty is ignored.
        rdreq = 1'b1;
        wait_clk(2);
        rdreq = 1'b0;
        @(negedge clk);
        check("pop empty usedw", 32'(usedw), 32'h0);
        check("pop empty flag", 32'(empty), 32'h1);

        // Back-to-back burst with no idle gap.
        fe0 = fe_cnt;
        for (int i = 1; i <= 12; i++) send_byte(8'(i), 1'b1);
        wait_clk(4);
        check("burst usedw", 32'(usedw), 32'd12);
        check("burst frame_err", 32'(fe_cnt - fe0), 32'h0);
        for (int i = 1; i <= 12; i++) pop_check($sformatf("burst pop%0d", i), 8'(i));
        @(negedge clk);
        check("burst drained", 32'(empty), 32'h1);

        // Overflow: 18 bytes into a 16-deep FIFO.
        for (int i = 0; i < 18; i++) begin
            send_byte(8'h40 + 8'(i), 1'b1);
            if (i == 15) begin
                wait_clk(2);
                check("ovf full at 16", 32'(full), 32'h1);
                check("ovf flag at 16", 32'(overflow), 32'h0);
            end
        end
        wait_clk(4);
        check("ovf usedw", 32'(usedw), 32'd16);
        check("ovf full", 32'(full), 32'h1);
        check("ovf flag", 32'(overflow), 32'h1);
        for (int i = 0; i < 16; i++) pop_check($sformatf("ovf pop%0d", i), 8'h40 + 8'(i));
        @(negedge clk);
        check("ovf drained", 32'(empty), 32'h1);
        check("ovf sticky", 32'(overflow), 32'h1);

        // Push and pop on the same cycle while full.
        do_reset();
        check("post-reset overflow", 32'(overflow), 32'h0);
        for (int i = 1; i <= 16; i++) send_byte(8'h80 + 8'(i), 1'b1);
        wait_clk(4);
        check("pp full", 32'(full), 32'h1);
        found = 1'b0;
        fork
            send_byte(8'h91, 1'b1);
            begin
                for (int k = 0; k < FRAME + 200; k++) begin
                    @(negedge clk);
                    if (dut.push) begin
                        found = 1'b1;
                        break;
                    end
                end
                if (found) begin
                    rdreq = 1'b1;
                    @(negedge clk);
                    rdreq = 1'b0;
                end
            end
        join
        check("pp push seen", 32'(found), 32'h1);
        wait_clk(4);
        check("pp usedw", 32'(usedw), 32'd16);
        check("pp overflow", 32'(overflow), 32'h0);
        for (int i = 2; i <= 17; i++) pop_check($sformatf("pp pop%0d", i), 8'h80 + 8'(i));
        @(negedge clk);
        check("pp drained", 32'(empty), 32'h1);

        // Asynchronous reset during data bit 4 of 0xFF with 5 bytes queued.
        for (int i = 0; i < 5; i++) send_byte(8'h20 + 8'(i), 1'b1);
        wait_clk(4);
        check("rst pre usedw", 32'(usedw), 32'd5);
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            wait_clk(BIT);
        end
        wait_clk(BIT / 2);
        reset = 1'b1;
        #1;
        check_reset_state("midframe reset");
        wait_clk(3);
        reset = 1'b0;
        wait_clk(2 * BIT);
        check("post rst usedw", 32'(usedw), 32'h0);
        fe0 = fe_cnt;
        send_byte(8'h5A, 1'b1);
        wait_clk(4);
        check("post rst rx usedw", 32'(usedw), 32'd1);
        check("post rst frame_err", 32'(fe_cnt - fe0), 32'h0);
        pop_check("post rst pop", 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
